sap1_controller: RTL and testbench

Control sequencer for the SAP-1 datapath. It is the initiator of every register load/enable strobe on the shared 8-bit bus:
- runs a 6-state ring counter (T1..T6) per instruction;
- decodes the 4-bit opcode from the instruction register;
- drives active-high load/enable lines to PC, MAR, RAM, IR, A, B, ALU and output register.

Also owns the halt state.

---
 rtl/sap1_pkg.sv | 38 +++
 rtl/sap1_ring_counter.sv | 24 ++
 rtl/sap1_controller.sv | 122 ++++++++++++
 tb/tb_sap1_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 control sequencer.
package sap1_pkg;

    localparam int OP_WIDTH = 4;
    localparam int NUM_T    = 6;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bit index of each T-state inside the one-hot ring.
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef struct packed {
        logic pc_inc;
        logic pc_out;
        logic mar_load;
        logic ram_out;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic out_load;
    } ctrl_word_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot rotating T-state counter; resets to T1 and advances only when enabled.
module sap1_ring_counter
    import sap1_pkg::*;
#(
    parameter int WIDTH = NUM_T
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] ring
);

    // Rotate left by one position per enabled clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (enable) begin
            ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
        end else begin
            ring <= ring;
        end
    end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: T-state ring, opcode decode to bus strobes, halt flag.
module sap1_controller
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OP_WIDTH-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                out_load,
    output logic                halted,
    output logic [NUM_T-1:0]    t_state
);

    logic       halt_now;
    logic       ring_en;
    ctrl_word_t cw;

    // HLT is caught in T4; the ring must not step past T4 on that same edge.
    assign halt_now = run & ~halted & t_state[T4] & (opcode == OP_HLT);
    assign ring_en  = run & ~halted & ~halt_now;

    sap1_ring_counter #(.WIDTH(NUM_T)) u_ring (
        .clk    (clk),
        .rst    (rst),
        .enable (ring_en),
        .ring   (t_state)
    );

    // Halt flag: set on the T4 edge of HLT, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end else begin
            halted <= halted;
        end
    end

    // Moore decode of T-state and opcode into the control word.
    always_comb begin
        cw = '0;
        if (halted) begin
            cw = '0;
        end else begin
            case (t_state)
                6'b000001: begin
                    cw.pc_out   = 1'b1;
                    cw.mar_load = 1'b1;
                end
                6'b000010: cw.pc_inc = 1'b1;
                6'b000100: begin
                    cw.ram_out = 1'b1;
                    cw.ir_load = 1'b1;
                end
                6'b001000: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw.ir_out   = 1'b1;
                            cw.mar_load = 1'b1;
                        end
                        OP_OUT: begin
                            cw.a_out    = 1'b1;
                            cw.out_load = 1'b1;
                        end
                        default: cw = '0;
                    endcase
                end
                6'b010000: begin
                    case (opcode)
                        OP_LDA: begin
                            cw.ram_out = 1'b1;
                            cw.a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.ram_out = 1'b1;
                            cw.b_load  = 1'b1;
                            cw.alu_sub = (opcode == OP_SUB);
                        end
                        default: cw = '0;
                    endcase
                end
                6'b100000: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            cw.alu_out = 1'b1;
                            cw.a_load  = 1'b1;
                            cw.alu_sub = (opcode == OP_SUB);
                        end
                        default: cw = '0;
                    endcase
                end
                default: cw = '0;
            endcase
        end
    end

    assign pc_inc   = cw.pc_inc;
    assign pc_out   = cw.pc_out;
    assign mar_load = cw.mar_load;
    assign ram_out  = cw.ram_out;
    assign ir_load  = cw.ir_load;
    assign ir_out   = cw.ir_out;
    assign a_load   = cw.a_load;
    assign a_out    = cw.a_out;
    assign b_load   = cw.b_load;
    assign alu_out  = cw.alu_out;
    assign alu_sub  = cw.alu_sub;
    assign out_load = cw.out_load;

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller: constant vector table, directed corner sequences, random run.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
    logic [5:0] t_state;

    int errors = 0;
    int checks = 0;

    sap1_controller dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .pc_inc(pc_inc), .pc_out(pc_out), .mar_load(mar_load), .ram_out(ram_out),
        .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
        .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load),
        .halted(halted), .t_state(t_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  t;
        logic [11:0] cw;
        logic        h;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic [3:0] op;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];

    // Reference model state: T index 0..5 and halt flag.
    int   m_t = 0;
    logic m_h = 1'b0;

    // Strobe bit order: pc_inc pc_out mar_load ram_out ir_load ir_out a_load a_out b_load alu_out alu_sub out_load
    function automatic logic [11:0] model_cw(int t, logic [3:0] op, logic h);
        if (h) return 12'h000;
        case (t)
            0: return 12'h600;
            1: return 12'h800;
            2: return 12'h180;
            3: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h240 :
                      (op == 4'hE) ? 12'h011 : 12'h000;
            4: return (op == 4'h0) ? 12'h120 : (op == 4'h1) ? 12'h108 :
                      (op == 4'h2) ? 12'h10A : 12'h000;
            5: return (op == 4'h1) ? 12'h024 : (op == 4'h2) ? 12'h026 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    function automatic exp_t model_next(logic r, logic rn, logic [3:0] op);
        exp_t e;
        if (r) begin
            m_t = 0;
            m_h = 1'b0;
        end else if (rn && !m_h) begin
            if (m_t == 3 && op == 4'hF) m_h = 1'b1;
            else m_t = (m_t + 1) % 6;
        end
        e.t  = 6'b000001 << m_t;
        e.h  = m_h;
        e.cw = model_cw(m_t, op, m_h);
        return e;
    endfunction

    task automatic check_outputs(string name);
        exp_t e;
        logic [11:0] got;
        int drivers;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        got = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, out_load};
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        checks += 4;
        if (t_state !== e.t) begin
            errors++;
            $display("FAIL %s t_state: got %b want %b", name, t_state, e.t);
        end
        if (got !== e.cw) begin
            errors++;
            $display("FAIL %s strobes: got %h want %h", name, got, e.cw);
        end
        if (halted !== e.h) begin
            errors++;
            $display("FAIL %s halted: got %b want %b", name, halted, e.h);
        end
        if (drivers > 1) begin
            errors++;
            $display("FAIL %s bus_drivers: got %0d want <=1", name, drivers);
        end
    endtask

    // Drive inputs, push expected, clock, compare #1 after the edge.
    task automatic step(logic r, logic rn, logic [3:0] op, bit use_tab, exp_t tab, string name);
        exp_t m;
        rst = r;
        run = rn;
        opcode = op;
        m = model_next(r, rn, op);
        exp_q.push_back(use_tab ? tab : m);
        @(posedge clk);
        #1;
        check_outputs(name);
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rn, logic [3:0] op, logic [5:0] t, logic [11:0] cw, logic h);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op;
        v.e.t = t; v.e.cw = cw; v.e.h = h;
        return v;
    endfunction

    exp_t dummy;

    initial begin
        dummy.t = 6'd0; dummy.cw = 12'd0; dummy.h = 1'b0;

        // Reset, then one LDA, SUB, OUT instruction and an HLT up to the halt edge.
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 6'b000001, 12'h600, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 6'b000001, 12'h600, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 6'b000010, 12'h800, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 6'b000100, 12'h180, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 6'b001000, 12'h240, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 6'b010000, 12'h120, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 6'b100000, 12'h000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 6'b000001, 12'h600, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 6'b000010, 12'h800, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 6'b000100, 12'h180, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 6'b001000, 12'h240, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 6'b010000, 12'h10A, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 6'b100000, 12'h026, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hE, 6'b000001, 12'h600, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hE, 6'b000010, 12'h800, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hE, 6'b000100, 12'h180, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hE, 6'b001000, 12'h011, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hE, 6'b010000, 12'h000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hE, 6'b100000, 12'h000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 6'b000001, 12'h600, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 6'b000010, 12'h800, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 6'b000100, 12'h180, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 6'b001000, 12'h000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 4'hF, 6'b001000, 12'h000, 1'b1));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].run, vecs[i].op, 1'b1, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Halted: ring frozen at T4, strobes low, regardless of run.
        for (int i = 0; i < 20; i++) step(1'b0, (i % 3) != 0, 4'hF, 1'b0, dummy, "halt_hold");
        step(1'b1, 1'b1, 4'hF, 1'b0, dummy, "halt_reset");

        // HLT at T4 with run=0 must not halt; ADD frozen in T5 by run=0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 1'b0, dummy, "hlt_to_t4");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'hF, 1'b0, dummy, "hlt_run0");
        step(1'b1, 1'b0, 4'h1, 1'b0, dummy, "rst_before_add");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h1, 1'b0, dummy, "add_to_t5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h1, 1'b0, dummy, "add_freeze");
        step(1'b0, 1'b1, 4'h1, 1'b0, dummy, "add_resume_t6");
        step(1'b0, 1'b1, 4'h1, 1'b0, dummy, "add_back_t1");

        // Reset mid-SUB at T5.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h2, 1'b0, dummy, "sub_to_t5");
        step(1'b1, 1'b1, 4'h2, 1'b0, dummy, "sub_midreset");

        // Random opcodes (changed only at T1), random run, occasional reset.
        begin
            logic [3:0] op_r;
            op_r = 4'h0;
            for (int i = 0; i < 1000; i++) begin
                if (m_t == 0) op_r = 4'($urandom_range(0, 15));
                step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, op_r, 1'b0, dummy, "random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
